// File: rtl/vdp_sched_pkg.sv
// ----------------------------------------------------------------------------
// vdp_sched_pkg: shared types for the VDP port scheduler.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package vdp_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    GAP    = 3'd4
  } state_e;

  typedef struct packed {
    logic       rd;
    logic       mode;
    logic [7:0] data;
  } entry_t;

  localparam int ENTRY_W = 10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vdp_sched_fifo.sv
// ----------------------------------------------------------------------------
// vdp_sched_fifo: synchronous FIFO holding queued CPU port accesses.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vdp_sched_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

`default_nettype wire

// File: rtl/vdp_port_scheduler.sv
// ----------------------------------------------------------------------------
// vdp_port_scheduler: queues CPU VDP port accesses and replays them as
// synchronizer-safe csw_n/csr_n strobes. Stats ports via VDP_SCHED_STATS_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vdp_port_scheduler
  import vdp_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STROBE_LEN = 4,
  parameter int GAP_LEN    = 8
) (
  input  logic                          clk,
  input  logic                          RESET,
  input  logic                          cpu_wr,
  input  logic                          cpu_rd,
  input  logic                          cpu_mode,
  input  logic [7:0]                    cpu_din,
  output logic [7:0]                    cpu_dout,
  output logic                          cpu_rvalid,
  output logic                          cpu_wait,
  output logic                          overflow,
  output logic                          vdp_csw_n,
  output logic                          vdp_csr_n,
  output logic                          vdp_mode,
  output logic [7:0]                    vdp_cd_o,
  input  logic [7:0]                    vdp_cd_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef VDP_SCHED_STATS_EN
  ,
  output logic [15:0]                   stat_wr,
  output logic [15:0]                   stat_rd,
  output logic [7:0]                    stat_drop
`endif
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(max_int(STROBE_LEN, GAP_LEN)) + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LVL_W-1:0]   rdcnt_q, rdcnt_d;
  entry_t             req_entry;
  entry_t             head_entry;
  logic [ENTRY_W-1:0] head_bits;
  logic               fifo_full, fifo_empty;
  logic               pop, req, accept, collide, drop;
  logic               last_strobe;
  logic               cur_rd_q, mode_q, csw_n_q, csr_n_q, rvalid_q, overflow_q;
  logic [7:0]         cd_q, dout_q;

  assign collide = cpu_wr & cpu_rd;
  assign req     = cpu_wr | cpu_rd;
  assign accept  = req & (~fifo_full | pop);
  assign drop    = collide | (req & ~accept);

  // On a wr/rd collision the write wins, so the entry is built from the write.
  always_comb begin
    req_entry      = '0;
    req_entry.rd   = ~cpu_wr;
    req_entry.mode = cpu_mode;
    req_entry.data = cpu_wr ? cpu_din : 8'h00;
  end

  assign head_entry = entry_t'(head_bits);

  vdp_sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_i   (RESET),
    .push_i  (accept),
    .din_i   (req_entry),
    .pop_i   (pop),
    .dout_o  (head_bits),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = CNT_W'(STROBE_LEN - 1);
      end
      STROBE: begin
        if (cnt_q == '0) state_d = HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      HOLD: begin
        state_d = GAP;
        cnt_d   = CNT_W'(GAP_LEN - 1);
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reads still waiting in the FIFO keep cpu_wait asserted.
  always_comb begin
    rdcnt_d = rdcnt_q;
    if (accept && req_entry.rd) rdcnt_d = rdcnt_d + 1'b1;
    if (pop && head_entry.rd)   rdcnt_d = rdcnt_d - 1'b1;
  end

  assign last_strobe = (state_q == STROBE) && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rdcnt_q    <= '0;
      cur_rd_q   <= 1'b0;
      mode_q     <= 1'b0;
      cd_q       <= 8'h00;
      csw_n_q    <= 1'b1;
      csr_n_q    <= 1'b1;
      rvalid_q   <= 1'b0;
      dout_q     <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdcnt_q  <= rdcnt_d;
      if (pop) begin
        cur_rd_q <= head_entry.rd;
        mode_q   <= head_entry.mode;
        cd_q     <= head_entry.data;
      end
      // Strobes are registered from the next state so the VDP sees clean edges.
      csw_n_q  <= ~((state_d == STROBE) & ~cur_rd_q);
      csr_n_q  <= ~((state_d == STROBE) &  cur_rd_q);
      rvalid_q <= last_strobe & cur_rd_q;
      if (last_strobe && cur_rd_q) dout_q <= vdp_cd_i;
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign vdp_csw_n  = csw_n_q;
  assign vdp_csr_n  = csr_n_q;
  assign vdp_mode   = mode_q;
  assign vdp_cd_o   = cd_q;
  assign cpu_dout   = dout_q;
  assign cpu_rvalid = rvalid_q;
  assign overflow   = overflow_q;
  assign cpu_wait   = fifo_full | (rdcnt_q != '0) |
                      (cur_rd_q & ((state_q == SETUP) | (state_q == STROBE)));

`ifdef VDP_SCHED_STATS_EN
  logic [15:0] stat_wr_q, stat_rd_q;
  logic [7:0]  stat_drop_q;
  logic [1:0]  drop_n;

  // A full FIFO during a collision drops both the write and the read.
  assign drop_n = {1'b0, collide} + {1'b0, req & ~accept};

  always_ff @(posedge clk) begin
    if (RESET) begin
      stat_wr_q   <= '0;
      stat_rd_q   <= '0;
      stat_drop_q <= '0;
    end else begin
      if (state_q == SETUP) begin
        if (cur_rd_q) stat_rd_q <= stat_rd_q + 1'b1;
        else          stat_wr_q <= stat_wr_q + 1'b1;
      end
      if (drop_n != 2'd0) begin
        if (stat_drop_q > (8'hFF - {6'd0, drop_n})) stat_drop_q <= 8'hFF;
        else                                      stat_drop_q <= stat_drop_q + {6'd0, drop_n};
      end
    end
  end

  assign stat_wr   = stat_wr_q;
  assign stat_rd   = stat_rd_q;
  assign stat_drop = stat_drop_q;
`endif

endmodule

`default_nettype wire
